io_mmrx: RTL and testbench
==========================

// Module: io_mmrx
// PURPOSE
//  Memory management for the IO channel receive data path: mirror of the transmit-side packet buffer.
//  Accepts the 16-bit word stream from the channel receiver and stores only complete, error-free packets.
//  Drops bad packets by rewinding the write pointer.
//  Presents stored packets to the downstream consumer through an rd_req/rd_dval read port, {sop,eop,data[15:0]}.
// PARAMETERS
//  ADDR_W   10      buffer address width; depth = 2**ADDR_W words of 18 bits
//  MAX_LEN  512     max words per packet, sop..eop inclusive; longer packets are dropped
//  MIN_LEN  3       min words per packet; shorter packets are dropped
// PORTS
//  clk_12_5m  in   1   single clock for the block
//  rst_12_5m  in   1   asynchronous, active-low reset
//  rx_dval    in   1   receive word valid
//  rx_sop     in   1   first word of packet; qualified by rx_dval
//  rx_eop     in   1   last word of packet; qualified by rx_dval
//  rx_data    in   16  receive word
//  rx_err     in   1   packet CRC/line error; sampled only with rx_dval&rx_eop
//  rd_req     in   1   consumer read request, one word per cycle
//  rd_dval    out  1   rd_data valid
//  rd_data    out  18  {sop,eop,data[15:0]}
//  mm_empty   out  1   1 = no committed unread words
//  pkt_cnt    out  ADDR_W+1  committed unread packets
//  drop_cnt   out  16  dropped-packet counter; saturates at 16'hFFFF
//  seq_err    out  1   1-cycle pulse on a packet-tick discontinuity
// BEHAVIOUR
//  Reset: all pointers=0, FSM=IDLE, rd_dval=0, rd_data=0, mm_empty=1, pkt_cnt=0, drop_cnt=0, seq_err=0, last_tick=0.
//   Buffer contents are lost, including any packet in progress.
//  Pointers: wr_cmt, wr_tmp and rd_ptr are ADDR_W+1 bits (extra wrap bit).
//   used = wr_tmp-rd_ptr, modulo 2**(ADDR_W+1).
//   full when used==2**ADDR_W.
//  Write FSM, states IDLE/RECV/DROP; all decisions are taken on rx_dval cycles:
//   IDLE: sop -> write word {1,eop,data} at wr_cmt; wr_tmp=wr_cmt+1; len=1; go RECV.
//         Non-sop words are ignored.
//   RECV: write each word at wr_tmp, then wr_tmp++, len++.
//         Word with len==1 (2nd word) is the packet tick.
//         If tick!=last_tick+1 (16-bit wrap): seq_err pulses the next cycle; the packet is still kept.
//         last_tick is updated on every packet commit.
//   Drop in RECV: full, len reaches MAX_LEN without eop, eop with rx_err, or eop with len<MIN_LEN.
//         Action: wr_tmp=wr_cmt, drop_cnt++, then IDLE if the word was eop, else DROP.
//   Commit: good eop -> wr_cmt=wr_tmp+1, pkt_cnt++, IDLE.
//   sop while in RECV: drop current packet (drop_cnt++); this word starts a new packet at wr_cmt.
//   DROP: ignore words until eop -> IDLE.
//         A sop while in DROP starts a new packet as in IDLE.
//  Read:
//   Accept when rd_req & (rd_ptr!=wr_cmt); rd_ptr++.
//   Uncommitted data is never readable; rd_req is ignored while empty.
//   RAM read latency is 1: rd_dval=1 in the cycle after an accepted rd_req, with rd_data valid that cycle.
//   rd_data holds its value when rd_dval=0.
//   Back-to-back requests give one word per cycle.
//  pkt_cnt: ++ on commit, -- on rd_dval & rd_data[16]; unchanged if both occur in the same cycle.
//  mm_empty is combinational: (rd_ptr==wr_cmt).
//  Full is checked against rd_ptr of the same cycle; a read in that cycle does not rescue the write.
// STRUCTURE
//  Shared package (defines include): RD_SOP_BIT=17, RD_EOP_BIT=16, FSM state encodings.
//  One sub-module: io_mmrx_dpram, a simple dual-port RAM.
//   Width 18, depth 2**ADDR_W, 1 write port, 1 registered read port, same clock.
//  FSM, pointers and counters live in io_mmrx.
// TESTING
//  1 Good packet: 4 words, tick=1 -> stored; mm_empty=0 and pkt_cnt=1 after eop.
//    Read: 4 rd_dval cycles, rd_data[17] on word0, rd_data[16] on word3, payload exact.
//    Afterwards mm_empty=1 and pkt_cnt=0.
//  2 rx_err with eop on a 5-word packet -> drop_cnt=1, mm_empty stays 1, wr_cmt unchanged.
//  3 sop after 3 words of packet A, then 4-word packet B -> drop_cnt=1; only B is read back, tick intact.
//  4 ADDR_W=4, no reads, packets of 6 words -> packets 1-2 stored, packet 3 overflows and is dropped.
//    After draining 12 words, a new packet is accepted.
//  5 Ticks 1,2,4 on three packets -> seq_err pulses once, on the third packet; all 3 are stored.
//  6 Commit of packet 2 in the same cycle rd_dval returns eop of packet 1 -> pkt_cnt stays 1.
//    Then reset mid-packet -> all outputs return to their reset values.

Source files
------------

// File: rtl/io_mmrx_pkg.sv
// io_mmrx_pkg
// Shared definitions for the IO channel receive-side packet buffer.
//   RD_SOP_BIT / RD_EOP_BIT : flag positions inside the 18-bit stored word
//   RD_WORD_W               : stored word width {sop, eop, data[15:0]}
//   wrState_t               : write-side packet FSM states
//   satAdd16                : saturating add used by the drop counter
package io_mmrx_pkg;

    localparam int RD_SOP_BIT = 17;
    localparam int RD_EOP_BIT = 16;
    localparam int RD_WORD_W  = 18;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DROP = 2'd2
    } wrState_t;

    // A single cycle can abandon one packet and reject the next one, so the
    // increment may be 0, 1 or 2; the counter sticks at all-ones.
    function automatic logic [15:0] satAdd16(input logic [15:0] a, input logic [1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, a} + {15'd0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/io_mmrx_dpram.sv
// io_mmrx_dpram
// Simple dual-port RAM, one write port and one registered read port on the
// same clock. The read register only loads when i_re is high, so the last
// word read is held on o_rdata between reads.
//   i_clk, i_rstN : clock, asynchronous active-low reset (read register only)
//   i_we, i_waddr, i_wdata : write port
//   i_re, i_raddr          : read request and address
//   o_rdata                : registered read data, one cycle after i_re
module io_mmrx_dpram
    import io_mmrx_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = RD_WORD_W
) (
    input  logic              i_clk,
    input  logic              i_rstN,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] r_rdata;

    // Storage array: no reset, contents are meaningless after reset because
    // all pointers return to zero.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read port; holds its value when no read is issued.
    always_ff @(posedge i_clk or negedge i_rstN) begin
        if (!i_rstN) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/io_mmrx.sv
// io_mmrx
// Receive-side packet buffer for the IO channel. Stores only complete,
// error-free packets of MIN_LEN..MAX_LEN words; bad packets are discarded by
// rewinding the temporary write pointer to the last committed position.
// Stored packets are read back one word per rd_req as {sop, eop, data}.
//   clk_12_5m, rst_12_5m : clock, asynchronous active-low reset
//   rx_dval/sop/eop/data/err : receiver word stream
//   rd_req, rd_dval, rd_data : consumer read port (1-cycle latency)
//   mm_empty  : no committed unread words
//   pkt_cnt   : committed packets whose eop has not yet been delivered
//   drop_cnt  : saturating count of discarded packets
//   seq_err   : one-cycle pulse when a packet tick is not last_tick+1
module io_mmrx
    import io_mmrx_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int MAX_LEN = 512,
    parameter int MIN_LEN = 3
) (
    input  logic                 clk_12_5m,
    input  logic                 rst_12_5m,
    input  logic                 rx_dval,
    input  logic                 rx_sop,
    input  logic                 rx_eop,
    input  logic [15:0]          rx_data,
    input  logic                 rx_err,
    input  logic                 rd_req,
    output logic                 rd_dval,
    output logic [RD_WORD_W-1:0] rd_data,
    output logic                 mm_empty,
    output logic [ADDR_W:0]      pkt_cnt,
    output logic [15:0]          drop_cnt,
    output logic                 seq_err
);

    localparam int               LEN_W   = $clog2(MAX_LEN + 1);
    localparam logic [ADDR_W:0]  DEPTH   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]  PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MIN_LEN);

    wrState_t              r_state;
    logic [ADDR_W:0]       r_wrCmt;
    logic [ADDR_W:0]       r_wrTmp;
    logic [ADDR_W:0]       r_rdPtr;
    logic [LEN_W-1:0]      r_len;
    logic [15:0]           r_curTick;
    logic [15:0]           r_lastTick;
    logic [ADDR_W:0]       r_pktCnt;
    logic [15:0]           r_dropCnt;
    logic                  r_seqErr;
    logic                  r_rdDval;

    wrState_t              w_nextState;
    logic [ADDR_W:0]       w_nextWrCmt;
    logic [ADDR_W:0]       w_nextWrTmp;
    logic [LEN_W-1:0]      w_nextLen;
    logic [LEN_W-1:0]      w_newLen;
    logic [15:0]           w_nextCurTick;
    logic [ADDR_W:0]       w_used;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_we;
    logic [ADDR_W-1:0]     w_waddr;
    logic [RD_WORD_W-1:0]  w_wdata;
    logic [1:0]            w_dropInc;
    logic                  w_commit;
    logic                  w_tickBad;
    logic                  w_rdAccept;
    logic                  w_rdEop;
    logic [RD_WORD_W-1:0]  w_ramQ;

    // Occupancy includes the packet still being received, so a long packet
    // can never overwrite committed data that has not been read yet.
    assign w_used     = r_wrTmp - r_rdPtr;
    assign w_full     = (w_used == DEPTH);
    assign w_empty    = (r_rdPtr == r_wrCmt);
    assign w_newLen   = r_len + LEN_ONE;
    assign w_rdAccept = rd_req & ~w_empty;
    assign w_rdEop    = r_rdDval & w_ramQ[RD_EOP_BIT];

    // Write-side decisions. Every decision is taken on an rx_dval cycle. A sop
    // always restarts at the committed pointer, abandoning any packet in
    // progress. A sop that also carries eop is a one-word packet and is
    // rejected immediately. In RECV the word is either appended or the whole
    // packet is discarded by rewinding wr_tmp; a good eop commits it.
    always_comb begin
        w_nextState   = r_state;
        w_nextWrCmt   = r_wrCmt;
        w_nextWrTmp   = r_wrTmp;
        w_nextLen     = r_len;
        w_nextCurTick = r_curTick;
        w_we          = 1'b0;
        w_waddr       = r_wrTmp[ADDR_W-1:0];
        w_wdata       = {2'b00, rx_data};
        w_wdata[RD_EOP_BIT] = rx_eop;
        w_dropInc     = 2'd0;
        w_commit      = 1'b0;
        w_tickBad     = 1'b0;
        if (rx_dval) begin
            if (rx_sop) begin
                if (r_state == ST_RECV) begin
                    w_dropInc = 2'd1;
                end
                w_nextWrTmp = r_wrCmt;
                w_nextLen   = '0;
                if (rx_eop || (r_state != ST_RECV && w_full)) begin
                    w_dropInc   = w_dropInc + 2'd1;
                    w_nextState = rx_eop ? ST_IDLE : ST_DROP;
                end else begin
                    w_we        = 1'b1;
                    w_waddr     = r_wrCmt[ADDR_W-1:0];
                    w_wdata[RD_SOP_BIT] = 1'b1;
                    w_nextWrTmp = r_wrCmt + PTR_ONE;
                    w_nextLen   = LEN_ONE;
                    w_nextState = ST_RECV;
                end
            end else if (r_state == ST_RECV) begin
                if (r_len == LEN_ONE) begin
                    w_nextCurTick = rx_data;
                    w_tickBad     = (rx_data != (r_lastTick + 16'd1));
                end
                if (w_full || (w_newLen == LEN_MAX && !rx_eop) ||
                    (rx_eop && (rx_err || w_newLen < LEN_MIN))) begin
                    w_dropInc   = 2'd1;
                    w_nextWrTmp = r_wrCmt;
                    w_nextLen   = '0;
                    w_nextState = rx_eop ? ST_IDLE : ST_DROP;
                end else begin
                    w_we        = 1'b1;
                    w_nextWrTmp = r_wrTmp + PTR_ONE;
                    w_nextLen   = w_newLen;
                    if (rx_eop) begin
                        w_commit    = 1'b1;
                        w_nextWrCmt = r_wrTmp + PTR_ONE;
                        w_nextState = ST_IDLE;
                    end
                end
            end else if (r_state == ST_DROP && rx_eop) begin
                w_nextState = ST_IDLE;
            end
        end
    end

    // Write-side state register: FSM state, write pointers, packet length,
    // tick tracking and the drop counter. last_tick only moves on a commit,
    // so ticks of discarded packets never disturb the sequence check.
    always_ff @(posedge clk_12_5m or negedge rst_12_5m) begin
        if (!rst_12_5m) begin
            r_state    <= ST_IDLE;
            r_wrCmt    <= '0;
            r_wrTmp    <= '0;
            r_len      <= '0;
            r_curTick  <= '0;
            r_lastTick <= '0;
            r_dropCnt  <= '0;
            r_seqErr   <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_wrCmt   <= w_nextWrCmt;
            r_wrTmp   <= w_nextWrTmp;
            r_len     <= w_nextLen;
            r_curTick <= w_nextCurTick;
            r_dropCnt <= satAdd16(r_dropCnt, w_dropInc);
            r_seqErr  <= w_tickBad;
            if (w_commit) begin
                r_lastTick <= w_nextCurTick;
            end
        end
    end

    // Read side: the pointer only advances over committed words, and
    // rd_dval follows an accepted request by exactly one cycle to line up
    // with the RAM's registered output. The packet count drops when an eop
    // word is actually delivered, not when it is requested.
    always_ff @(posedge clk_12_5m or negedge rst_12_5m) begin
        if (!rst_12_5m) begin
            r_rdPtr  <= '0;
            r_rdDval <= 1'b0;
            r_pktCnt <= '0;
        end else begin
            r_rdDval <= w_rdAccept;
            if (w_rdAccept) begin
                r_rdPtr <= r_rdPtr + PTR_ONE;
            end
            if (w_commit && !w_rdEop) begin
                r_pktCnt <= r_pktCnt + PTR_ONE;
            end else if (!w_commit && w_rdEop) begin
                r_pktCnt <= r_pktCnt - PTR_ONE;
            end
        end
    end

    io_mmrx_dpram #(
        .ADDR_W (ADDR_W),
        .DATA_W (RD_WORD_W)
    ) u_dpram (
        .i_clk   (clk_12_5m),
        .i_rstN  (rst_12_5m),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_re    (w_rdAccept),
        .i_raddr (r_rdPtr[ADDR_W-1:0]),
        .o_rdata (w_ramQ)
    );

    assign rd_dval  = r_rdDval;
    assign rd_data  = w_ramQ;
    assign mm_empty = w_empty;
    assign pkt_cnt  = r_pktCnt;
    assign drop_cnt = r_dropCnt;
    assign seq_err  = r_seqErr;

endmodule

// File: tb/tb_io_mmrx.sv
// tb_io_mmrx
// Self-checking bench for io_mmrx with a small buffer (16 words) so overflow
// is easy to reach. A queue-based model tracks committed words, the packet
// in progress, counters and tick sequence; every cycle all outputs are
// compared against it on the falling edge.
module tb_io_mmrx;
    import io_mmrx_pkg::*;

    localparam int ADDR_W  = 4;
    localparam int MAX_LEN = 8;
    localparam int MIN_LEN = 3;
    localparam int DEPTH   = 1 << ADDR_W;

    logic              clk_12_5m = 1'b0;
    logic              rst_12_5m = 1'b0;
    logic              rx_dval   = 1'b0;
    logic              rx_sop    = 1'b0;
    logic              rx_eop    = 1'b0;
    logic [15:0]       rx_data   = '0;
    logic              rx_err    = 1'b0;
    logic              rd_req    = 1'b0;
    logic              rd_dval;
    logic [17:0]       rd_data;
    logic              mm_empty;
    logic [ADDR_W:0]   pkt_cnt;
    logic [15:0]       drop_cnt;
    logic              seq_err;

    int checkCount = 0;
    int failCount  = 0;
    int seqPulses  = 0;

    // Reference model state
    logic [17:0] storeQ[$];
    logic [17:0] curQ[$];
    bit          inPkt;
    bit          discard;
    logic [15:0] mdlTick;
    logic [15:0] mdlLastTick;
    logic [15:0] mdlDrops;
    int          mdlPktCnt;
    bit          expDval;
    logic [17:0] expData;
    bit          expSeq;
    logic [15:0] nextTick;

    io_mmrx #(
        .ADDR_W  (ADDR_W),
        .MAX_LEN (MAX_LEN),
        .MIN_LEN (MIN_LEN)
    ) dut (
        .clk_12_5m (clk_12_5m),
        .rst_12_5m (rst_12_5m),
        .rx_dval   (rx_dval),
        .rx_sop    (rx_sop),
        .rx_eop    (rx_eop),
        .rx_data   (rx_data),
        .rx_err    (rx_err),
        .rd_req    (rd_req),
        .rd_dval   (rd_dval),
        .rd_data   (rd_data),
        .mm_empty  (mm_empty),
        .pkt_cnt   (pkt_cnt),
        .drop_cnt  (drop_cnt),
        .seq_err   (seq_err)
    );

    // 12.5 MHz clock
    always #40 clk_12_5m = ~clk_12_5m;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit reqRoll(input int pct);
        return $urandom_range(99) < pct;
    endfunction

    task automatic modelReset();
        storeQ.delete();
        curQ.delete();
        inPkt       = 1'b0;
        discard     = 1'b0;
        mdlTick     = '0;
        mdlLastTick = '0;
        mdlDrops    = '0;
        mdlPktCnt   = 0;
        expDval     = 1'b0;
        expData     = '0;
        expSeq      = 1'b0;
    endtask

    task automatic mdlDrop();
        if (mdlDrops != 16'hFFFF) mdlDrops++;
    endtask

    // One clock edge of the reference behaviour, using the inputs the DUT
    // just sampled. Writes are judged against the occupancy before this
    // edge's read, then the read pops the oldest committed word.
    task automatic modelStep();
        bit          acc;
        bit          prevDval;
        logic [17:0] prevData;
        logic [17:0] word;
        int          n;
        prevDval = expDval;
        prevData = expData;
        acc      = rd_req && (storeQ.size() != 0);
        expSeq   = 1'b0;
        word     = {rx_sop, rx_eop, rx_data};
        if (rx_dval) begin
            if (rx_sop) begin
                if (inPkt) begin
                    mdlDrop();
                    curQ.delete();
                end
                inPkt   = 1'b0;
                discard = 1'b0;
                if (storeQ.size() == DEPTH) begin
                    mdlDrop();
                    discard = !rx_eop;
                end else begin
                    curQ.push_back(word);
                    inPkt = 1'b1;
                end
            end else if (inPkt) begin
                n = curQ.size() + 1;
                if (curQ.size() == 1) begin
                    mdlTick = rx_data;
                    expSeq  = (rx_data != 16'(mdlLastTick + 16'd1));
                end
                if ((storeQ.size() + curQ.size() == DEPTH) || (n == MAX_LEN && !rx_eop) ||
                    (rx_eop && (rx_err || n < MIN_LEN))) begin
                    mdlDrop();
                    curQ.delete();
                    inPkt   = 1'b0;
                    discard = !rx_eop;
                end else begin
                    curQ.push_back(word);
                    if (rx_eop) begin
                        foreach (curQ[i]) storeQ.push_back(curQ[i]);
                        curQ.delete();
                        inPkt = 1'b0;
                        mdlPktCnt++;
                        mdlLastTick = mdlTick;
                    end
                end
            end else if (discard && rx_eop) begin
                discard = 1'b0;
            end
        end
        if (prevDval && prevData[RD_EOP_BIT]) mdlPktCnt--;
        expDval = acc;
        if (acc) expData = storeQ.pop_front();
    endtask

    task automatic compareAll();
        checkOutput("rd_dval",  32'(rd_dval),  32'(expDval));
        checkOutput("rd_data",  32'(rd_data),  32'(expData));
        checkOutput("mm_empty", 32'(mm_empty), 32'(storeQ.size() == 0));
        checkOutput("pkt_cnt",  32'(pkt_cnt),  32'(mdlPktCnt));
        checkOutput("drop_cnt", 32'(drop_cnt), 32'(mdlDrops));
        checkOutput("seq_err",  32'(seq_err),  32'(expSeq));
        if (seq_err === 1'b1) seqPulses++;
    endtask

    // Drive one cycle of inputs (from a falling edge), let the model follow
    // the rising edge, and compare on the next falling edge.
    task automatic applyStimulus(input bit dval, input bit sop, input bit eop,
                                 input logic [15:0] data, input bit err, input bit req);
        rx_dval = dval;
        rx_sop  = sop;
        rx_eop  = eop;
        rx_data = data;
        rx_err  = err;
        rd_req  = req;
        @(posedge clk_12_5m);
        modelStep();
        @(negedge clk_12_5m);
        compareAll();
    endtask

    task automatic idle(input int n, input int reqPct);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, reqRoll(reqPct));
    endtask

    task automatic sendPkt(input int len, input logic [15:0] tick, input bit err,
                           input bit noEop, input int reqPct, input int gapPct);
        logic [15:0] d;
        bit          last;
        for (int i = 0; i < len; i++) begin
            if (i != 0 && reqRoll(gapPct)) idle(1, reqPct);
            d    = (i == 1) ? tick : 16'($urandom);
            last = (i == len - 1) && !noEop;
            applyStimulus(1'b1, i == 0, last, d, last && err, reqRoll(reqPct));
        end
    endtask

    task automatic resetDut();
        rx_dval = 1'b0;
        rx_sop  = 1'b0;
        rx_eop  = 1'b0;
        rx_err  = 1'b0;
        rd_req  = 1'b0;
        rst_12_5m = 1'b0;
        modelReset();
        @(negedge clk_12_5m);
        compareAll();
        checkOutput("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        checkOutput("rst_pkt_cnt",  32'(pkt_cnt),  32'd0);
        checkOutput("rst_mm_empty", 32'(mm_empty), 32'd1);
        checkOutput("rst_rd_data",  32'(rd_data),  32'd0);
        rst_12_5m = 1'b1;
    endtask

    initial begin
        int          len;
        bit          err;
        bit          cut;
        int          reqPct;
        logic [15:0] tk;

        modelReset();
        repeat (2) @(negedge clk_12_5m);
        compareAll();
        rst_12_5m = 1'b1;
        @(negedge clk_12_5m);

        $display("[TB] good 4-word packet then read back");
        sendPkt(4, 16'd1, 1'b0, 1'b0, 0, 0);
        checkOutput("t1_pkt_cnt_after_eop", 32'(pkt_cnt), 32'd1);
        checkOutput("t1_not_empty", 32'(mm_empty), 32'd0);
        idle(4, 100);
        idle(2, 0);
        checkOutput("t1_empty_after_read", 32'(mm_empty), 32'd1);
        checkOutput("t1_pkt_cnt_after_read", 32'(pkt_cnt), 32'd0);

        $display("[TB] errored eop drops packet");
        sendPkt(5, 16'd2, 1'b1, 1'b0, 0, 0);
        checkOutput("t2_drop_cnt", 32'(drop_cnt), 32'd1);
        checkOutput("t2_empty", 32'(mm_empty), 32'd1);

        $display("[TB] sop interrupts packet A, packet B kept");
        sendPkt(3, 16'd2, 1'b0, 1'b1, 0, 0);
        sendPkt(4, 16'd2, 1'b0, 1'b0, 0, 0);
        checkOutput("t3_drop_cnt", 32'(drop_cnt), 32'd2);
        idle(6, 100);

        $display("[TB] overflow of a 16-word buffer");
        sendPkt(6, 16'd3, 1'b0, 1'b0, 0, 0);
        sendPkt(6, 16'd4, 1'b0, 1'b0, 0, 0);
        sendPkt(6, 16'd5, 1'b0, 1'b0, 0, 0);
        checkOutput("t4_drop_cnt", 32'(drop_cnt), 32'd3);
        checkOutput("t4_pkt_cnt", 32'(pkt_cnt), 32'd2);
        idle(12, 100);
        idle(2, 0);
        checkOutput("t4_drained_empty", 32'(mm_empty), 32'd1);
        sendPkt(4, 16'd5, 1'b0, 1'b0, 0, 0);
        checkOutput("t4_new_pkt_accepted", 32'(pkt_cnt), 32'd1);
        idle(6, 100);

        $display("[TB] tick discontinuity");
        seqPulses = 0;
        sendPkt(4, 16'd6, 1'b0, 1'b0, 0, 0);
        sendPkt(4, 16'd7, 1'b0, 1'b0, 0, 0);
        sendPkt(4, 16'd9, 1'b0, 1'b0, 0, 0);
        idle(1, 0);
        checkOutput("t5_seq_pulses", 32'(seqPulses), 32'd1);
        checkOutput("t5_all_stored", 32'(pkt_cnt), 32'd3);
        idle(14, 100);

        $display("[TB] commit and eop delivery in the same cycle");
        sendPkt(4, 16'd10, 1'b0, 1'b0, 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'hA000, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd11,   1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'hA002, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'hA003, 1'b0, 1'b0);
        checkOutput("t6_pkt_cnt_same_cycle", 32'(pkt_cnt), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'hB000, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'd12,   1'b0, 1'b0);
        resetDut();
        @(negedge clk_12_5m);

        $display("[TB] randomized packet traffic");
        nextTick = 16'd1;
        for (int p = 0; p < 80; p++) begin
            len    = $urandom_range(2, 10);
            err    = ($urandom_range(7) == 0);
            cut    = ($urandom_range(9) == 0);
            reqPct = (p < 40) ? 20 : 70;
            tk     = nextTick;
            if ($urandom_range(9) == 0) tk = tk + 16'd1;
            nextTick = tk + 16'd1;
            sendPkt(len, tk, err, cut, reqPct, 15);
            if ($urandom_range(11) == 0) begin
                applyStimulus(1'b1, 1'b0, 1'($urandom_range(1)), 16'($urandom), 1'b0, reqRoll(reqPct));
            end
            idle($urandom_range(0, 2), reqPct);
        end
        sendPkt(4, nextTick, 1'b0, 1'b0, 0, 0);
        idle(40, 100);
        checkOutput("final_empty", 32'(mm_empty), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
